instr_mem_sync: RTL and testbench

Parametrised, synchronous instruction memory for the ARM calculator core. It supersedes the hard-coded combinational instruction table with a RAM that the testbench or a loader writes at run time. Reads use a registered fetch handshake with one-cycle latency, and misaligned or out-of-range fetches are flagged. It sits between the PC/fetch stage and the program loader.

---
 rtl/instr_mem_sync_pkg.sv | 16 +
 rtl/instr_mem_sync_if.sv | 39 +++
 rtl/instr_mem_sync_imem_array.sv | 31 +++
 rtl/instr_mem_sync.sv | 108 ++++++++++
 tb/tb_instr_mem_sync.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/instr_mem_sync_pkg.sv
// Shared definitions for the synchronous instruction memory: FSM encodings,
// default bus widths and the word returned for faulted or unwritten fetches.
package instr_mem_sync_pkg;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_PROG = 1'b1
    } state_e;

    localparam int unsigned DEFAULT_ADDR_W = 32;
    localparam int unsigned DEFAULT_DATA_W = 32;

    // All-zero word doubles as the NOP/fill pattern for the calculator core.
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/instr_mem_sync_if.sv
// Fetch and program-load bus between the fetch stage/loader (master) and the
// instruction memory (slave).
interface instr_mem_sync_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 7
);

    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_ready;
    logic              fetch_valid;
    logic [DATA_W-1:0] fetch_data;
    logic              fetch_fault;

    logic              prog_start;
    logic              prog_done;
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;
    logic              load_err;
    logic [CNT_W-1:0]  load_count;
    logic              prog_mode;

    modport master (
        output fetch_req, fetch_addr, prog_start, prog_done,
               load_en, load_addr, load_data,
        input  fetch_ready, fetch_valid, fetch_data, fetch_fault,
               load_err, load_count, prog_mode
    );

    modport slave (
        input  fetch_req, fetch_addr, prog_start, prog_done,
               load_en, load_addr, load_data,
        output fetch_ready, fetch_valid, fetch_data, fetch_fault,
               load_err, load_count, prog_mode
    );

endinterface

// File: rtl/instr_mem_sync_imem_array.sv
// DEPTH x DATA_W storage with one write port and one registered read port.
// The read register only updates on a read enable, so it holds between fetches.
module imem_array #(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned DATA_W = 32,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [IDX_W-1:0]  raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/instr_mem_sync.sv
// Run-time loadable instruction memory: RUN serves one-cycle fetches with
// alignment/range faults, PROG accepts loader writes and counts them.
module instr_mem_sync
    import instr_mem_sync_pkg::*;
#(
    parameter int unsigned       ADDR_W    = DEFAULT_ADDR_W,
    parameter int unsigned       DATA_W    = DEFAULT_DATA_W,
    parameter int unsigned       DEPTH     = 64,
    parameter logic [DATA_W-1:0] FILL_WORD = DATA_W'(NOP_WORD)
) (
    input logic             clk,
    input logic             reset,
    instr_mem_sync_if.slave imem_bus
);

    localparam int unsigned      IDX_W     = $clog2(DEPTH);
    localparam int unsigned      CNT_W     = IDX_W + 1;
    localparam logic [CNT_W-1:0] COUNT_MAX = CNT_W'(DEPTH);

    state_e           state_q, state_d;
    logic             fetchValid_q, fetchValid_d;
    logic             fetchFault_q, fetchFault_d;
    logic             useFill_q, useFill_d;
    logic             loadErr_q, loadErr_d;
    logic [CNT_W-1:0] loadCount_q, loadCount_d;

    logic              fetchAccept;
    logic              fetchBad;
    logic              loadGood;
    logic              ramRead;
    logic [DATA_W-1:0] ramRdata;

    // Anything at or above DEPTH*4 has a nonzero bit above the word index.
    assign fetchBad = (imem_bus.fetch_addr[1:0] != 2'b00)
                   || ((imem_bus.fetch_addr >> (IDX_W + 2)) != '0);

    assign fetchAccept = imem_bus.fetch_req && (state_q == ST_RUN);
    assign ramRead     = fetchAccept && !fetchBad;

    assign loadGood = imem_bus.load_en
                   && (state_q == ST_PROG)
                   && (imem_bus.load_addr[1:0] == 2'b00)
                   && ((imem_bus.load_addr >> (IDX_W + 2)) == '0);

    always_comb begin
        state_d      = state_q;
        loadCount_d  = loadCount_q;
        fetchValid_d = fetchAccept;
        fetchFault_d = fetchAccept && fetchBad;
        useFill_d    = fetchAccept ? fetchBad : useFill_q;
        loadErr_d    = imem_bus.load_en && !loadGood;

        if (state_q == ST_RUN) begin
            if (imem_bus.prog_start) begin
                state_d     = ST_PROG;
                loadCount_d = '0;
            end
        end else begin
            if (imem_bus.prog_done) begin
                state_d = ST_RUN;
            end
            if (loadGood && (loadCount_q != COUNT_MAX)) begin
                loadCount_d = loadCount_q + 1'b1;
            end
        end
    end

    // useFill_q comes out of reset set so fetch_data shows FILL_WORD before any read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_RUN;
            fetchValid_q <= 1'b0;
            fetchFault_q <= 1'b0;
            useFill_q    <= 1'b1;
            loadErr_q    <= 1'b0;
            loadCount_q  <= '0;
        end else begin
            state_q      <= state_d;
            fetchValid_q <= fetchValid_d;
            fetchFault_q <= fetchFault_d;
            useFill_q    <= useFill_d;
            loadErr_q    <= loadErr_d;
            loadCount_q  <= loadCount_d;
        end
    end

    imem_array #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_array (
        .clk_i   (clk),
        .we_i    (loadGood),
        .waddr_i (imem_bus.load_addr[IDX_W+1:2]),
        .wdata_i (imem_bus.load_data),
        .re_i    (ramRead),
        .raddr_i (imem_bus.fetch_addr[IDX_W+1:2]),
        .rdata_o (ramRdata)
    );

    assign imem_bus.fetch_ready = (state_q == ST_RUN);
    assign imem_bus.prog_mode   = (state_q == ST_PROG);
    assign imem_bus.fetch_valid = fetchValid_q;
    assign imem_bus.fetch_fault = fetchFault_q;
    assign imem_bus.fetch_data  = useFill_q ? FILL_WORD : ramRdata;
    assign imem_bus.load_err    = loadErr_q;
    assign imem_bus.load_count  = loadCount_q;

endmodule

// File: tb/tb_instr_mem_sync.sv
// Directed bench for instr_mem_sync (DEPTH=64): loading, fetching, faults,
// count saturation, mode-change corner cases and reset during PROG.
module tb_instr_mem_sync;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 64;
    localparam int CNT_W  = 7;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    instr_mem_sync_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    instr_mem_sync #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .FILL_WORD (32'h0000_0000)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .imem_bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkFetch(input string tag, input logic valid, input logic fault,
                              input logic [31:0] data);
        checkOutput({tag, ".valid"}, 64'(bus.fetch_valid), 64'(valid));
        checkOutput({tag, ".fault"}, 64'(bus.fetch_fault), 64'(fault));
        checkOutput({tag, ".data"},  64'(bus.fetch_data),  64'(data));
    endtask

    task automatic idleInputs();
        bus.fetch_req  = 1'b0;
        bus.fetch_addr = '0;
        bus.prog_start = 1'b0;
        bus.prog_done  = 1'b0;
        bus.load_en    = 1'b0;
        bus.load_addr  = '0;
        bus.load_data  = '0;
    endtask

    // Drive one cycle of inputs, then advance past the edge that samples them.
    task automatic applyStimulus(input logic freq, input logic [31:0] faddr,
                                 input logic pstart, input logic pdone,
                                 input logic len, input logic [31:0] laddr,
                                 input logic [31:0] ldata);
        bus.fetch_req  = freq;
        bus.fetch_addr = faddr;
        bus.prog_start = pstart;
        bus.prog_done  = pdone;
        bus.load_en    = len;
        bus.load_addr  = laddr;
        bus.load_data  = ldata;
        tick();
    endtask

    initial begin
        idleInputs();
        reset = 1'b1;
        #12;
        checkOutput("rst.fetch_valid", 64'(bus.fetch_valid), 64'd0);
        checkOutput("rst.fetch_fault", 64'(bus.fetch_fault), 64'd0);
        checkOutput("rst.fetch_data",  64'(bus.fetch_data),  64'd0);
        checkOutput("rst.load_err",    64'(bus.load_err),    64'd0);
        checkOutput("rst.load_count",  64'(bus.load_count),  64'd0);
        checkOutput("rst.prog_mode",   64'(bus.prog_mode),   64'd0);
        checkOutput("rst.fetch_ready", 64'(bus.fetch_ready), 64'd1);
        reset = 1'b0;

        // Fill every word (only the last is nonzero) with fetch_req held high.
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        checkOutput("fill.prog_mode",   64'(bus.prog_mode),   64'd1);
        checkOutput("fill.fetch_ready", 64'(bus.fetch_ready), 64'd0);
        checkOutput("fill.count0",      64'(bus.load_count),  64'd0);
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1, 0, 0, 0, 1, 32'(i * 4), (i == DEPTH - 1) ? 32'hCAFE_0063 : 32'h0);
            checkOutput("fill.count",   64'(bus.load_count),  64'(i + 1));
            checkOutput("fill.novalid", 64'(bus.fetch_valid), 64'd0);
        end
        applyStimulus(1, 0, 0, 0, 1, 32'h0, 32'h0);
        checkOutput("sat.count65", 64'(bus.load_count), 64'd64);
        applyStimulus(1, 0, 0, 0, 1, 32'h4, 32'h0);
        checkOutput("sat.count66", 64'(bus.load_count), 64'd64);
        checkOutput("sat.load_err", 64'(bus.load_err), 64'd0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        checkOutput("sat.prog_mode",   64'(bus.prog_mode),   64'd0);
        checkOutput("sat.fetch_ready", 64'(bus.fetch_ready), 64'd1);
        checkOutput("sat.count_kept",  64'(bus.load_count),  64'd64);
        applyStimulus(1, 252, 0, 0, 0, 0, 0);
        checkFetch("sat.fetch252", 1, 0, 32'hCAFE_0063);

        // Program two words; the second rides on the prog_done cycle.
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 32'h0, 32'hE209_9F00);
        checkOutput("prog.count1", 64'(bus.load_count), 64'd1);
        applyStimulus(0, 0, 0, 1, 1, 32'h4, 32'hE381_1F63);
        checkOutput("prog.count2",    64'(bus.load_count), 64'd2);
        checkOutput("prog.done_mode", 64'(bus.prog_mode),  64'd0);
        checkOutput("prog.done_err",  64'(bus.load_err),   64'd0);
        applyStimulus(1, 32'h0, 0, 0, 0, 0, 0);
        checkFetch("run.fetch0", 1, 0, 32'hE209_9F00);
        applyStimulus(1, 32'h4, 0, 0, 0, 0, 0);
        checkFetch("run.fetch4", 1, 0, 32'hE381_1F63);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkFetch("run.hold", 0, 0, 32'hE381_1F63);
        checkOutput("run.count2", 64'(bus.load_count), 64'd2);

        applyStimulus(1, 32'h2, 0, 0, 0, 0, 0);
        checkFetch("fault.addr2", 1, 1, 32'h0);
        applyStimulus(1, 32'h100, 0, 0, 0, 0, 0);
        checkFetch("fault.addr256", 1, 1, 32'h0);
        applyStimulus(1, 32'h8000_0000, 0, 0, 0, 0, 0);
        checkFetch("fault.addr_hi", 1, 1, 32'h0);
        applyStimulus(1, 32'h0, 0, 0, 0, 0, 0);
        checkFetch("fault.recover", 1, 0, 32'hE209_9F00);
        applyStimulus(1, 32'hFC, 0, 0, 0, 0, 0);
        checkFetch("fault.top_word", 1, 0, 32'hCAFE_0063);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkFetch("fault.idle", 0, 0, 32'hCAFE_0063);

        // A write attempted in RUN must be rejected and leave the word untouched.
        applyStimulus(0, 0, 0, 0, 1, 32'h8, 32'hDEAD_BEEF);
        checkOutput("runload.err", 64'(bus.load_err), 64'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("runload.err_pulse", 64'(bus.load_err), 64'd0);
        applyStimulus(1, 32'h8, 0, 0, 0, 0, 0);
        checkFetch("runload.fetch8", 1, 0, 32'h0);
        checkOutput("runload.count", 64'(bus.load_count), 64'd2);

        applyStimulus(1, 32'h4, 1, 0, 0, 0, 0);
        checkFetch("edge.fetch_at_start", 1, 0, 32'hE381_1F63);
        checkOutput("edge.prog_mode",   64'(bus.prog_mode),   64'd1);
        checkOutput("edge.fetch_ready", 64'(bus.fetch_ready), 64'd0);
        checkOutput("edge.count_clear", 64'(bus.load_count),  64'd0);
        applyStimulus(1, 32'h0, 0, 0, 1, 32'h104, 32'h1234_5678);
        checkOutput("prog.range_err",   64'(bus.load_err),    64'd1);
        checkOutput("prog.range_count", 64'(bus.load_count),  64'd0);
        checkOutput("prog.novalid",     64'(bus.fetch_valid), 64'd0);
        applyStimulus(1, 32'h0, 0, 0, 1, 32'hA, 32'h1234_5678);
        checkOutput("prog.align_err",   64'(bus.load_err),    64'd1);
        checkOutput("prog.align_count", 64'(bus.load_count),  64'd0);
        applyStimulus(1, 32'h0, 0, 0, 1, 32'h10, 32'h1111_1111);
        applyStimulus(1, 32'h0, 0, 0, 1, 32'h14, 32'h2222_2222);
        applyStimulus(1, 32'h0, 0, 0, 1, 32'h18, 32'h3333_3333);
        checkOutput("prog.count3",  64'(bus.load_count),  64'd3);
        checkOutput("prog.err_low", 64'(bus.load_err),    64'd0);
        checkOutput("prog.novalid3", 64'(bus.fetch_valid), 64'd0);

        idleInputs();
        reset = 1'b1;
        #2;
        checkOutput("midrst.prog_mode",  64'(bus.prog_mode),  64'd0);
        checkOutput("midrst.load_count", 64'(bus.load_count), 64'd0);
        reset = 1'b0;
        #1;
        checkOutput("midrst.fetch_ready", 64'(bus.fetch_ready), 64'd1);
        applyStimulus(1, 32'h10, 0, 0, 0, 0, 0);
        checkFetch("midrst.word4", 1, 0, 32'h1111_1111);
        applyStimulus(1, 32'h14, 0, 0, 0, 0, 0);
        checkFetch("midrst.word5", 1, 0, 32'h2222_2222);
        applyStimulus(1, 32'h18, 0, 0, 0, 0, 0);
        checkFetch("midrst.word6", 1, 0, 32'h3333_3333);

        // Reset right after a fetch completes drops the pulse and restores fill data.
        idleInputs();
        reset = 1'b1;
        #2;
        checkFetch("dropvalid", 0, 0, 32'h0);
        reset = 1'b0;

        applyStimulus(0, 0, 1, 1, 0, 0, 0);
        checkOutput("both.run_enters_prog", 64'(bus.prog_mode), 64'd1);
        applyStimulus(0, 0, 1, 1, 0, 0, 0);
        checkOutput("both.prog_leaves",     64'(bus.prog_mode),   64'd0);
        checkOutput("both.ready",           64'(bus.fetch_ready), 64'd1);
        idleInputs();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
